fwd_hazard_ctrl: RTL

Forwarding and load-use hazard controller for the 5-stage pipeline. It tracks the destination registers of instructions in flight in EX and MEM, and drives the 2-bit selects of the two 64-bit 4:1 operand muxes that feed the ALU. It stalls ID/IF for one cycle on a load-use hazard, inserts a bubble into EX, and counts stall cycles.

---
 rtl/fwd_pkg.sv | 23 ++
 rtl/fwd_match.sv | 31 +++
 rtl/fwd_hazard_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard controller: the operand-mux
// select encoding, the XZR index and the per-stage destination tracking record.
package fwd_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    // Order matches the data inputs of the two ALU operand muxes.
    typedef enum logic [1:0] {
        SEL_RF    = 2'd0,
        SEL_EXMEM = 2'd1,
        SEL_MEMWB = 2'd2,
        SEL_ZERO  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } stage_info_t;

endpackage

// File: rtl/fwd_match.sv
// Compares one source register against the EX and MEM producers and picks the
// operand-mux select for it (XZR, then newest producer, then older producer).
module fwd_match
    import fwd_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             src_en,
    input  stage_info_t      ex_info,
    input  stage_info_t      mem_info,
    output logic             hit_ex,
    output logic             hit_mem,
    output logic [1:0]       sel
);

    // MEM-stage loads forward through MEM/WB like any other result.
    logic unused_mem_memread;
    assign unused_mem_memread = mem_info.memread;

    assign hit_ex  = ex_info.valid  && ex_info.regwrite  && (ex_info.rd  == src) && (src != ZERO_REG);
    assign hit_mem = mem_info.valid && mem_info.regwrite && (mem_info.rd == src) && (src != ZERO_REG);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sel = SEL_RF;
        if (!src_en)               sel = SEL_RF;
        else if (src == ZERO_REG)  sel = SEL_ZERO;
        else if (hit_ex)           sel = SEL_EXMEM;
        else if (hit_mem)          sel = SEL_MEMWB;
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control: tracks EX/MEM destinations, registers
// the ALU operand-mux selects, stalls IF/ID one cycle on load-use and counts stalls.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_info_t      ex_q, ex_d, mem_q, mem_d;
    logic [1:0]       fwd_a_sel_q, fwd_a_sel_d, fwd_b_sel_q, fwd_b_sel_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       hit_ex_a, hit_ex_b;
    logic       hit_mem_a_unused, hit_mem_b_unused;
    logic [1:0] sel_a, sel_b;
    logic       load_use;

    fwd_match u_match_a (
        .src      (id_rn),
        .src_en   (1'b1),
        .ex_info  (ex_q),
        .mem_info (mem_q),
        .hit_ex   (hit_ex_a),
        .hit_mem  (hit_mem_a_unused),
        .sel      (sel_a)
    );

    fwd_match u_match_b (
        .src      (id_rm),
        .src_en   (id_uses_rm),
        .ex_info  (ex_q),
        .mem_info (mem_q),
        .hit_ex   (hit_ex_b),
        .hit_mem  (hit_mem_b_unused),
        .sel      (sel_b)
    );

    // A load in EX cannot forward yet; hit_ex already excludes XZR.
    assign load_use = id_valid && ex_q.memread &&
                      (hit_ex_a || (id_uses_rm && hit_ex_b));
    assign stall    = load_use && !flush;

    always_comb begin
        mem_d       = ex_q;
        ex_d        = ex_q;
        ex_d.valid  = 1'b0;
        fwd_a_sel_d = SEL_RF;
        fwd_b_sel_d = SEL_RF;
        stall_cnt_d = stall_cnt_q;
        if (id_valid && !flush && !load_use) begin
            ex_d        = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
            fwd_a_sel_d = sel_a;
            fwd_b_sel_d = sel_b;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            fwd_a_sel_q <= SEL_RF;
            fwd_b_sel_q <= SEL_RF;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a_sel = fwd_a_sel_q;
    assign fwd_b_sel = fwd_b_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule
